spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI mode-0 master. It sits directly upstream of spi_slave and drives that block's spi_clk and mosi inputs.
- Accepts a parallel word plus a transfer size from the host side on t_start.
- Shifts the word out MSB-first on mosi while capturing miso.
- Returns the received bits on d_out_m with a one-cycle done pulse.

Parameters:
- reg_width, 8, shift register / data word width.
- counter_width, $clog2(reg_width), bit-counter width; t_size_m is counter_width+1 bits.
- clk_div, 2, master_clk cycles per spi_clk half-period (legal range >= 1).

Ports:
- master_clk  input  1  system clock.
- rst  input  1  reset. Asynchronous assert, active-high.
- t_start  input  1  transfer request, sampled only in idle.
- d_in_m  input  reg_width  transmit word, MSB sent first.
- t_size_m  input  counter_width+1  number of bits to transfer (0..reg_width).
- d_out_m  output  reg_width  received bits, right-aligned, upper bits zero.
- done  output  1  one-cycle pulse when d_out_m updates.
- busy  output  1  high from load through unload inclusive.
- spi_clk  output  1  serial clock, idles low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.
- cs_n  output  1  chip select, active-low.

Behaviour:
- One clock, master_clk. Reset is asynchronous and active-high (rst). There is no other clock domain.
- Reset state:
  - state=idle.
  - spi_clk=0, mosi=0, cs_n=1.
  - d_out_m=0, done=0, busy=0.
  - All counters and shift registers cleared.
- Reset asserted mid-transfer aborts the transfer immediately (asynchronously). No done pulse is produced.
- States are idle, load, transact, unload.
- idle:
  - t_start=1 at a master_clk edge goes to load.
  - t_start is ignored in every other state; no queuing.
- load (1 cycle):
  - Latch d_in_m into tx_sr.
  - Latch t_size_m into n. If t_size_m > reg_width, n = reg_width.
  - Clear rx_sr, bit_cnt and half_cnt.
  - cs_n=0; mosi=d_in_m[reg_width-1].
  - If n=0, go to unload. Otherwise go to transact.
- transact:
  - half_cnt counts 0..clk_div-1. At terminal count, spi_clk toggles and half_cnt wraps to 0.
  - Rising edge of spi_clk: rx_sr <= {rx_sr[reg_width-2:0], miso}.
  - Falling edge of spi_clk: bit_cnt increments.
    - If bit_cnt+1 == n, go to unload; spi_clk stays low.
    - Otherwise tx_sr shifts left by 1 and mosi takes the new MSB.
  - mosi only changes on falling edges (or in load), so it is stable across every rising edge.
- unload (1 cycle):
  - d_out_m <= rx_sr, with bits above n equal to 0 by construction.
  - done=1; cs_n=1.
  - Next state is idle.
- Latency: t_start sampled at edge T gives load at T+1, transact for 2*clk_div*n cycles, then unload. done is high during cycle T+2+2*clk_div*n.
- d_out_m holds its value until the next unload or reset.
- spi_clk is always low in idle, load and unload.
- Edge case, t_size_m=0: no spi_clk edges occur, d_out_m=0, and done fires 2 cycles after t_start is sampled.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding (idle=1, load=2, transact=3, unload=4; reset code 0 reserved, matching spi_slave);
  - the default reg_width.
- One sub-module, spi_clk_gen, holds:
  - the half_cnt divider;
  - the spi_clk register;
  - single-cycle rise/fall strobes, enabled only in transact and cleared on load.

Test Plan:
- clk_div=2, miso looped to mosi, d_in_m=8'h55, t_size_m=8, pulse t_start:
  - cs_n falls at load;
  - 8 spi_clk pulses with period 4 cycles;
  - done exactly 34 cycles after t_start is sampled;
  - d_out_m=8'h55; busy low the cycle after done.
- Same loopback, d_in_m=8'hAA, t_size_m=8: mosi sequence 1,0,1,0,1,0,1,0 sampled at spi_clk rises, and d_out_m=8'hAA.
- Partial transfer, d_in_m=8'hA5, t_size_m=4, loopback: exactly 4 spi_clk pulses, mosi sends 1,0,1,0, and d_out_m=8'h0A.
- t_size_m=0 and t_size_m=15 (clamp):
  - size 0: no spi_clk toggles, done 2 cycles after start, d_out_m=8'h00;
  - size 15: behaves as 8 bits.
- t_start pulsed again mid-transact: ignored, with only one done pulse and the first word's result. Connected to spi_slave (d_in_s=8'h3C, d_in_m=8'hC3): master d_out_m=8'h3C.
- rst raised during the 3rd bit: spi_clk=0, cs_n=1, busy=0 and d_out_m=0 immediately. After release, a new transfer of 8'h55 completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI master and its clock generator.
//
//   Contents:
//     spi_state_e            - controller state encoding. Code 0 is reserved
//                              as a reset code so the encoding lines up with
//                              spi_slave; the master itself resets to idle.
//     SPI_DEFAULT_REG_WIDTH  - default shift register / data word width.
//     SPI_DEFAULT_CLK_DIV    - default master_clk cycles per spi_clk half-period.
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_TRANSACT = 3'd3,
        ST_UNLOAD   = 3'd4
    } spi_state_e;

    localparam int SPI_DEFAULT_REG_WIDTH = 8;
    localparam int SPI_DEFAULT_CLK_DIV   = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
//   Divides master_clk down to the SPI serial clock. While enabled, a
//   half-period counter runs 0..clk_div-1; at its terminal count the serial
//   clock toggles and the counter wraps. The rise/fall strobes are asserted
//   for the single master_clk cycle whose closing edge makes spi_clk toggle,
//   so the controller acts on exactly the same edge as the serial clock.
//
//   Ports:
//     clk_i      in   master clock
//     rst_i      in   asynchronous active-high reset
//     en_i       in   run the divider (controller is transacting)
//     clr_i      in   clear divider and force serial clock low (load cycle)
//     spi_clk_o  out  serial clock, idles low
//     rise_o     out  spi_clk goes 0->1 at the next clk_i edge
//     fall_o     out  spi_clk goes 1->0 at the next clk_i edge
// ---------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int clk_div = SPI_DEFAULT_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic spi_clk_o,
    output logic rise_o,
    output logic fall_o
);

    // A divide of 1 still needs a one-bit counter to keep the code uniform.
    localparam int HW = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(clk_div - 1);

    logic [HW-1:0] half_cnt_q;
    logic          sclk_q;
    logic          tc;

    assign tc = en_i && (half_cnt_q == HALF_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            half_cnt_q <= '0;
            sclk_q     <= 1'b0;
        end else if (clr_i) begin
            half_cnt_q <= '0;
            sclk_q     <= 1'b0;
        end else if (en_i) begin
            if (tc) begin
                half_cnt_q <= '0;
                sclk_q     <= ~sclk_q;
            end else begin
                half_cnt_q <= half_cnt_q + HW'(1);
            end
        end
    end

    assign spi_clk_o = sclk_q;
    assign rise_o    = tc && !sclk_q;
    assign fall_o    = tc &&  sclk_q;

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//   SPI mode-0 master. A transfer request on t_start (honoured only in idle)
//   latches a word and a bit count, shifts the word out MSB-first on mosi
//   while capturing miso on each spi_clk rising edge, and returns the
//   received bits right-aligned on d_out_m together with a one-cycle done.
//
//   Sequence: idle -> load (1 cycle) -> transact (2*clk_div*n cycles)
//             -> unload (1 cycle) -> idle.  A zero-length transfer skips
//             transact entirely.
//
//   Ports:
//     master_clk  in   system clock
//     rst         in   asynchronous active-high reset, aborts any transfer
//     t_start     in   transfer request
//     d_in_m      in   transmit word, MSB first
//     t_size_m    in   bits to transfer, values above reg_width clamp
//     d_out_m     out  received bits, right-aligned, held until next unload
//     done        out  one-cycle pulse when d_out_m updates
//     busy        out  high from load through unload
//     spi_clk     out  serial clock, idles low
//     mosi        out  serial data out, changes only on spi_clk falls / load
//     miso        in   serial data in, sampled on spi_clk rises
//     cs_n        out  chip select, active low for load and transact
// ---------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int reg_width     = SPI_DEFAULT_REG_WIDTH,
    parameter int counter_width = $clog2(reg_width),
    parameter int clk_div       = SPI_DEFAULT_CLK_DIV
) (
    input  logic                     master_clk,
    input  logic                     rst,
    input  logic                     t_start,
    input  logic [reg_width-1:0]     d_in_m,
    input  logic [counter_width:0]   t_size_m,
    output logic [reg_width-1:0]     d_out_m,
    output logic                     done,
    output logic                     busy,
    output logic                     spi_clk,
    output logic                     mosi,
    input  logic                     miso,
    output logic                     cs_n
);

    localparam int SZ_W = counter_width + 1;
    localparam logic [SZ_W-1:0] N_MAX = SZ_W'(reg_width);

    function automatic logic [SZ_W-1:0] clamp_size(input logic [SZ_W-1:0] sz);
        return (sz > N_MAX) ? N_MAX : sz;
    endfunction

    spi_state_e            state_q;
    logic [reg_width-1:0]  tx_sr_q;
    logic [reg_width-1:0]  rx_sr_q;
    logic [reg_width-1:0]  d_out_q;
    logic [SZ_W-1:0]       n_q;
    logic [SZ_W-1:0]       bit_cnt_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  cs_n_q;

    logic [SZ_W-1:0]       n_d;
    logic [SZ_W-1:0]       bit_cnt_d;
    logic                  sclk;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  gen_en;
    logic                  gen_clr;
    logic                  last_fall;
    logic                  enter_unload;

    assign n_d       = clamp_size(t_size_m);
    assign bit_cnt_d = bit_cnt_q + SZ_W'(1);
    assign gen_en    = (state_q == ST_TRANSACT);
    assign gen_clr   = (state_q == ST_LOAD);

    // The falling edge that completes bit n ends the transfer; spi_clk is
    // driven low by that same edge, so it is already idle in unload.
    assign last_fall    = gen_en && sclk_fall && (bit_cnt_d == n_q);
    assign enter_unload = last_fall || ((state_q == ST_LOAD) && (n_q == '0));

    spi_clk_gen #(
        .clk_div (clk_div)
    ) u_clk_gen (
        .clk_i     (master_clk),
        .rst_i     (rst),
        .en_i      (gen_en),
        .clr_i     (gen_clr),
        .spi_clk_o (sclk),
        .rise_o    (sclk_rise),
        .fall_o    (sclk_fall)
    );

    // Outputs are registered so that they take their load/unload values
    // during those cycles: the edge that enters a state also sets its outputs.
    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            d_out_q   <= '0;
            n_q       <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (t_start) begin
                        state_q   <= ST_LOAD;
                        tx_sr_q   <= d_in_m;
                        n_q       <= n_d;
                        rx_sr_q   <= '0;
                        bit_cnt_q <= '0;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q <= (n_q == '0) ? ST_UNLOAD : ST_TRANSACT;
                end
                ST_TRANSACT: begin
                    if (sclk_rise) begin
                        rx_sr_q <= {rx_sr_q[reg_width-2:0], miso};
                    end
                    if (sclk_fall) begin
                        bit_cnt_q <= bit_cnt_d;
                        if (last_fall) begin
                            state_q <= ST_UNLOAD;
                        end else begin
                            // mosi is the MSB of tx_sr, so it only moves here.
                            tx_sr_q <= {tx_sr_q[reg_width-2:0], 1'b0};
                        end
                    end
                end
                ST_UNLOAD: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                end
            endcase

            // rx_sr was cleared at load, so unused upper bits read as zero.
            if (enter_unload) begin
                d_out_q <= rx_sr_q;
                done_q  <= 1'b1;
                cs_n_q  <= 1'b1;
            end
        end
    end

    assign d_out_m = d_out_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign spi_clk = sclk;
    assign mosi    = tx_sr_q[reg_width-1];
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    logic       master_clk = 1'b0;
    logic       rst        = 1'b1;
    logic       t_start    = 1'b0;
    logic [7:0] d_in_m     = 8'h00;
    logic [3:0] t_size_m   = 4'd0;
    logic [7:0] d_out_m;
    logic       done;
    logic       busy;
    logic       spi_clk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    // Slave-side model and loopback select
    logic       use_slave = 1'b0;
    logic [7:0] d_in_s    = 8'h3C;
    logic [7:0] s_rx      = 8'h00;
    int         s_idx     = 0;
    logic [2:0] s_sel;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic       mon_mosi[$];
    int         rise_cyc[$];
    int         cyc       = 0;
    int         toggles   = 0;
    int         dones     = 0;
    logic       sclk_prev = 1'b0;

    spi_master #(
        .reg_width     (8),
        .counter_width (3),
        .clk_div       (2)
    ) dut (
        .master_clk (master_clk),
        .rst        (rst),
        .t_start    (t_start),
        .d_in_m     (d_in_m),
        .t_size_m   (t_size_m),
        .d_out_m    (d_out_m),
        .done       (done),
        .busy       (busy),
        .spi_clk    (spi_clk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n)
    );

    always #5 master_clk = ~master_clk;

    assign s_sel = 3'(7 - s_idx);
    assign miso  = use_slave ? ((s_idx < 8) ? d_in_s[s_sel] : 1'b0) : mosi;

    // Slave receive: mode 0 samples mosi on spi_clk rising edges.
    always @(posedge spi_clk) s_rx <= {s_rx[6:0], mosi};

    // Monitor on the inactive edge; also advances the slave transmit index
    // after each spi_clk fall while selected.
    always @(negedge master_clk) begin
        cyc       <= cyc + 1;
        sclk_prev <= spi_clk;
        if (spi_clk && !sclk_prev) begin
            mon_mosi.push_back(mosi);
            rise_cyc.push_back(cyc);
        end
        if (spi_clk != sclk_prev) toggles <= toggles + 1;
        if (done) dones <= dones + 1;
        if (cs_n) s_idx <= 0;
        else if (!spi_clk && sclk_prev) s_idx <= s_idx + 1;
    end

    task automatic step();
        @(negedge master_clk);
        #1;
    endtask

    // Starts a transfer, pushes the modelled result, and waits for done.
    // lat counts cycles from the t_start sampling edge; -1 on timeout.
    task automatic run_xfer(input logic [7:0] d, input logic [3:0] sz, input int poke,
                            output int lat, output logic ld_cs_n, output logic ld_busy);
        int n;
        logic [7:0] src;
        logic [7:0] e;
        n   = (sz > 4'd8) ? 8 : int'(sz);
        src = use_slave ? d_in_s : d;
        e   = (n == 0) ? 8'h00 : (src >> (8 - n));
        exp_q.push_back(e);
        d_in_m   = d;
        t_size_m = sz;
        t_start  = 1'b1;
        step();
        t_start = 1'b0;
        ld_cs_n = cs_n;
        ld_busy = busy;
        lat = 1;
        while (!done && lat < 400) begin
            t_start = (lat == poke);
            if (lat == poke) begin
                d_in_m   = 8'hFF;
                t_size_m = 4'd2;
            end
            step();
            lat++;
        end
        t_start = 1'b0;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL reset_spi_clk: got %b want 0", spi_clk); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        total++; if (d_out_m !== 8'h00) begin bad++; $display("FAIL reset_d_out: got %h want 00", d_out_m); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_55();
        int lat, base, dmin, dmax, nr;
        logic lcs, lbusy;
        logic [7:0] e;
        base = rise_cyc.size();
        run_xfer(8'h55, 4'd8, 0, lat, lcs, lbusy);
        total++; if (lcs !== 1'b0) begin bad++; $display("FAIL basic_cs_n_load: got %b want 0", lcs); end
        total++; if (lbusy !== 1'b1) begin bad++; $display("FAIL basic_busy_load: got %b want 1", lbusy); end
        total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency: got %0d want 34", lat); end
        nr = rise_cyc.size() - base;
        total++; if (nr !== 8) begin bad++; $display("FAIL basic_rises: got %0d want 8", nr); end
        dmin = 1000; dmax = 0;
        for (int i = base + 1; i < rise_cyc.size(); i++) begin
            if (rise_cyc[i] - rise_cyc[i-1] < dmin) dmin = rise_cyc[i] - rise_cyc[i-1];
            if (rise_cyc[i] - rise_cyc[i-1] > dmax) dmax = rise_cyc[i] - rise_cyc[i-1];
        end
        total++; if (dmin !== 4 || dmax !== 4) begin bad++; $display("FAIL basic_period: got min %0d max %0d want 4", dmin, dmax); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL basic_d_out: got %h want %h", d_out_m, e); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_pattern_aa();
        int lat, base;
        logic lcs, lbusy;
        logic [7:0] e;
        logic [7:0] pat;
        pat  = 8'hAA;
        base = mon_mosi.size();
        run_xfer(pat, 4'd8, 0, lat, lcs, lbusy);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (base + i >= mon_mosi.size() || mon_mosi[base + i] !== pat[7 - i]) begin
                bad++; $display("FAIL aa_mosi_bit%0d: got %b want %b", i,
                                (base + i < mon_mosi.size()) ? mon_mosi[base + i] : 1'bx, pat[7 - i]);
            end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL aa_d_out: got %h want %h", d_out_m, e); end
        step();
    endtask

    task automatic test_partial();
        int lat, base, nr;
        logic lcs, lbusy;
        logic [7:0] e;
        logic [7:0] pat;
        pat  = 8'hA5;
        base = mon_mosi.size();
        run_xfer(pat, 4'd4, 0, lat, lcs, lbusy);
        total++; if (lat !== 18) begin bad++; $display("FAIL partial_latency: got %0d want 18", lat); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (base + i >= mon_mosi.size() || mon_mosi[base + i] !== pat[7 - i]) begin
                bad++; $display("FAIL partial_mosi_bit%0d: want %b", i, pat[7 - i]);
            end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL partial_d_out: got %h want %h", d_out_m, e); end
        repeat (4) step();
        nr = mon_mosi.size() - base;
        total++; if (nr !== 4) begin bad++; $display("FAIL partial_rises: got %0d want 4", nr); end
    endtask

    task automatic test_size_edges();
        int lat, t0, base, nr;
        logic lcs, lbusy;
        logic [7:0] e;
        t0 = toggles;
        run_xfer(8'hFF, 4'd0, 0, lat, lcs, lbusy);
        total++; if (lat !== 2) begin bad++; $display("FAIL zero_latency: got %0d want 2", lat); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL zero_d_out: got %h want %h", d_out_m, e); end
        step();
        step();
        total++; if (toggles - t0 !== 0) begin bad++; $display("FAIL zero_toggles: got %0d want 0", toggles - t0); end
        base = rise_cyc.size();
        run_xfer(8'h96, 4'd15, 0, lat, lcs, lbusy);
        total++; if (lat !== 34) begin bad++; $display("FAIL clamp_latency: got %0d want 34", lat); end
        nr = rise_cyc.size() - base;
        total++; if (nr !== 8) begin bad++; $display("FAIL clamp_rises: got %0d want 8", nr); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL clamp_d_out: got %h want %h", d_out_m, e); end
        step();
    endtask

    task automatic test_restart_ignored();
        int lat, d0;
        logic lcs, lbusy;
        logic [7:0] e;
        d0 = dones;
        run_xfer(8'h5A, 4'd8, 10, lat, lcs, lbusy);
        total++; if (lat !== 34) begin bad++; $display("FAIL restart_latency: got %0d want 34", lat); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL restart_d_out: got %h want %h", d_out_m, e); end
        repeat (40) step();
        total++; if (dones - d0 !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", dones - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy: got %b want 0", busy); end
    endtask

    task automatic test_slave();
        int lat;
        logic lcs, lbusy;
        logic [7:0] e;
        use_slave = 1'b1;
        d_in_s    = 8'h3C;
        run_xfer(8'hC3, 4'd8, 0, lat, lcs, lbusy);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL slave_d_out: got %h want %h", d_out_m, e); end
        total++; if (s_rx !== 8'hC3) begin bad++; $display("FAIL slave_rx: got %h want c3", s_rx); end
        step();
        use_slave = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int base, k, d0, lat;
        logic lcs, lbusy;
        logic [7:0] e;
        base     = rise_cyc.size();
        d_in_m   = 8'h55;
        t_size_m = 4'd8;
        t_start  = 1'b1;
        step();
        t_start = 1'b0;
        k = 0;
        while (rise_cyc.size() < base + 3 && k < 200) begin step(); k++; end
        total++; if (rise_cyc.size() < base + 3) begin bad++; $display("FAIL abort_reach_bit3: got %0d rises want 3", rise_cyc.size() - base); end
        #2 rst = 1'b1;
        #1;
        total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL abort_spi_clk: got %b want 0", spi_clk); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL abort_cs_n: got %b want 1", cs_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (d_out_m !== 8'h00) begin bad++; $display("FAIL abort_d_out: got %h want 00", d_out_m); end
        d0 = dones;
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        total++; if (dones !== d0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones - d0); end
        run_xfer(8'h55, 4'd8, 0, lat, lcs, lbusy);
        total++; if (lat !== 34) begin bad++; $display("FAIL abort_retry_latency: got %0d want 34", lat); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (d_out_m !== e) begin bad++; $display("FAIL abort_retry_d_out: got %h want %h", d_out_m, e); end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_55();
        test_pattern_aa();
        test_partial();
        test_size_edges();
        test_restart_ignored();
        test_slave();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
